shift_issue_unit: RTL and testbench
===================================

SHIFT_ISSUE_UNIT -- requirements
Module: shift_issue_unit

Interface
REQ-001 Parameter ZERO_WIDE, default 1: when 1, shift amounts >= 32 force a zero result; when 0, the amount is taken modulo 32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 clear  input  1  reset, asynchronous and active-high.
REQ-004 bus_in  input  32  datapath bus; carries operand, then shift amount.
REQ-005 start  input  1  captures bus_in as operand; honoured only in IDLE.
REQ-006 amt_valid  input  1  captures bus_in as shift amount; honoured only in WAIT_AMT.
REQ-007 shf_result  input  32  combinational result returned by the downstream shift-left unit.
REQ-008 shf_operand  output  32  operand driven to the shift-left unit; registered.
REQ-009 shf_amount  output  5  amount driven to the shift-left unit; registered.
REQ-010 z_out  output  32  registered result (Z register).
REQ-011 ovf  output  1  set when any 1 bit is shifted out past bit 31.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  single-cycle completion pulse.

Function
REQ-014 FSM states: IDLE, WAIT_AMT, EXEC, DONE; encoding is free.
REQ-015 IDLE & start: op_reg <= bus_in; next state is WAIT_AMT.
REQ-016 WAIT_AMT & amt_valid: amt_reg <= bus_in (all 32 bits); next state is EXEC. Without amt_valid, the FSM waits indefinitely.
REQ-017 shf_operand = op_reg and shf_amount = amt_reg[4:0] at all times.
REQ-018 EXEC lasts exactly 1 cycle; z_out and ovf load at the EXEC->DONE edge.
REQ-019 In DONE, done = 1 for exactly 1 cycle; the next state is IDLE unconditionally.
REQ-020 Latency: done is high in the second cycle after the edge that samples amt_valid.
REQ-021 Wide amount: if ZERO_WIDE = 1 and amt_reg[31:5] != 0, then z_out <= 0 (shf_result is ignored) and ovf <= (op_reg != 0).
REQ-022 Normal case: z_out <= shf_result; ovf <= 1 iff amount != 0 and any of op_reg[31 : 32-amount] is 1.
REQ-023 Amount 0: z_out <= op_reg and ovf <= 0.
REQ-024 ZERO_WIDE = 0: only amt_reg[4:0] is used, and REQ-022/023 apply.
REQ-025 start outside IDLE and amt_valid outside WAIT_AMT are ignored and change no state.
REQ-026 start and amt_valid high together in IDLE: only start acts, and amt_valid is not remembered.
REQ-027 z_out and ovf hold their values until the next EXEC->DONE edge, including while the next operation is in progress.
REQ-028 No combinational path from any input to busy, done, z_out or ovf.

Reset
REQ-029 While clear = 1, the FSM goes to IDLE and op_reg, amt_reg, z_out, ovf, busy and done are all 0 immediately, without waiting for a clock.
REQ-030 If clear is asserted mid-operation (WAIT_AMT or EXEC), the operation is aborted, no done is issued, and z_out reads 0.
REQ-031 After clear deasserts, the first rising edge may accept start.

Verification
REQ-032 Basic operation: start with bus_in = 0x0000_0001, then amt_valid with bus_in = 4 -> z_out = 0x0000_0010, ovf = 0, done pulses once at the required latency.
REQ-033 Overflow: operand 0x8000_0001, amount 1 -> z_out = 0x0000_0002, ovf = 1.
REQ-034 Wide amount: operand 0x0000_00FF, amount 0x0000_0020 -> with ZERO_WIDE = 1, z_out = 0 and ovf = 1; with ZERO_WIDE = 0, z_out = 0x0000_00FF and ovf = 0.
REQ-035 Amount 0: operand 0xDEAD_BEEF, amount 0 -> z_out = 0xDEAD_BEEF, ovf = 0.
REQ-036 Ignored strobes: a second start while in WAIT_AMT with bus_in = 0x1234 -> op_reg is unchanged, and the result uses the first operand.
REQ-037 Reset mid-operation: clear pulsed asynchronously during EXEC -> busy = 0, z_out = 0, no done pulse; a following operation with operand 3 and amount 2 completes with z_out = 0x0000_000C.

Source files
------------

// File: rtl/shift_issue_unit.sv
// -----------------------------------------------------------------------------
// shift_issue_unit
//
// Sequences one shift-left operation over a shared 32-bit bus: the operand is
// captured on start, the shift amount on amt_valid, the external shift-left
// unit is driven from registers, and its combinational result is captured
// into the Z register one cycle later together with an overflow flag.
//
// Parameters
//   ZERO_WIDE   1: amounts >= 32 force a zero result; 0: amount taken mod 32
//
// Ports
//   clk         clock, all state changes on the rising edge
//   clear       asynchronous active-high reset
//   bus_in      [31:0] operand, then shift amount
//   start       capture bus_in as operand (IDLE only)
//   amt_valid   capture bus_in as shift amount (WAIT_AMT only)
//   shf_result  [31:0] result from the downstream shift-left unit
//   shf_operand [31:0] registered operand to the shift-left unit
//   shf_amount  [4:0]  registered amount to the shift-left unit
//   z_out       [31:0] registered result
//   ovf         a 1 bit was shifted out past bit 31
//   busy        high in every state except IDLE
//   done        one-cycle completion pulse
// -----------------------------------------------------------------------------
module shift_issue_unit #(
    parameter int unsigned ZERO_WIDE = 1
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [31:0] bus_in,
    input  logic        start,
    input  logic        amt_valid,
    input  logic [31:0] shf_result,
    output logic [31:0] shf_operand,
    output logic [4:0]  shf_amount,
    output logic [31:0] z_out,
    output logic        ovf,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_AMT = 2'd1;
    localparam logic [1:0] EXEC     = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic [31:0] op_reg;
    logic [31:0] amt_reg;
    logic [31:0] z_reg;
    logic        ovf_reg;

    logic [4:0]  amt_low;
    logic        wide_amt;
    logic [31:0] spill;
    logic [31:0] z_next;
    logic        ovf_next;

    assign amt_low  = amt_reg[4:0];
    assign wide_amt = (ZERO_WIDE != 0) && (amt_reg[31:5] != 27'd0);

    // Operand bit gi leaves the word when gi + amount reaches 32. An amount
    // of zero never spills, so no separate zero test is needed here.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_spill
            assign spill[gi] = op_reg[gi] & (({1'b0, amt_low} + 6'(gi)) >= 6'd32);
        end
    endgenerate

    always_comb begin
        z_next   = shf_result;
        ovf_next = |spill;
        if (wide_amt) begin
            z_next   = 32'd0;
            ovf_next = |op_reg;
        end else if (amt_low == 5'd0) begin
            // Pass the operand straight through rather than trusting the
            // external unit for the identity case.
            z_next   = op_reg;
            ovf_next = 1'b0;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (start)     state_next = WAIT_AMT;
            WAIT_AMT: if (amt_valid) state_next = EXEC;
            EXEC:                    state_next = DONE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_reg <= IDLE;
            op_reg    <= 32'd0;
            amt_reg   <= 32'd0;
            z_reg     <= 32'd0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                op_reg <= bus_in;
            end
            if (state_reg == WAIT_AMT && amt_valid) begin
                amt_reg <= bus_in;
            end
            // Result registers only move on the EXEC->DONE edge and hold
            // through the following operation.
            if (state_reg == EXEC) begin
                z_reg   <= z_next;
                ovf_reg <= ovf_next;
            end
        end
    end

    assign shf_operand = op_reg;
    assign shf_amount  = amt_low;
    assign z_out       = z_reg;
    assign ovf         = ovf_reg;
    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);

endmodule

// File: tb/tb_shift_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_shift_issue_unit
//
// Two instances share the same stimulus: dut_zw (ZERO_WIDE = 1) and dut_mod
// (ZERO_WIDE = 0). Each has its own behavioural shift-left unit feeding
// shf_result. Directed vectors come from a table, then hand-written sequences
// cover ignored strobes and a mid-operation clear, then random operations are
// checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_shift_issue_unit;

    logic        clk = 1'b0;
    logic        clear;
    logic [31:0] bus_in;
    logic        start;
    logic        amt_valid;

    logic [31:0] shf_result_zw, shf_operand_zw, z_out_zw;
    logic [4:0]  shf_amount_zw;
    logic        ovf_zw, busy_zw, done_zw;

    logic [31:0] shf_result_mod, shf_operand_mod, z_out_mod;
    logic [4:0]  shf_amount_mod;
    logic        ovf_mod, busy_mod, done_mod;

    int checks = 0;
    int errors = 0;

    logic [31:0] prev_z_zw, prev_z_mod;
    logic [4:0]  prev_amt;

    always #5 clk = ~clk;

    // Downstream shift-left units
    assign shf_result_zw  = shf_operand_zw  << shf_amount_zw;
    assign shf_result_mod = shf_operand_mod << shf_amount_mod;

    shift_issue_unit #(.ZERO_WIDE(1)) dut_zw (
        .clk         (clk),
        .clear       (clear),
        .bus_in      (bus_in),
        .start       (start),
        .amt_valid   (amt_valid),
        .shf_result  (shf_result_zw),
        .shf_operand (shf_operand_zw),
        .shf_amount  (shf_amount_zw),
        .z_out       (z_out_zw),
        .ovf         (ovf_zw),
        .busy        (busy_zw),
        .done        (done_zw)
    );

    shift_issue_unit #(.ZERO_WIDE(0)) dut_mod (
        .clk         (clk),
        .clear       (clear),
        .bus_in      (bus_in),
        .start       (start),
        .amt_valid   (amt_valid),
        .shf_result  (shf_result_mod),
        .shf_operand (shf_operand_mod),
        .shf_amount  (shf_amount_mod),
        .z_out       (z_out_mod),
        .ovf         (ovf_mod),
        .busy        (busy_mod),
        .done        (done_mod)
    );

    typedef struct {
        logic [31:0] op;
        logic [31:0] amt;
        logic [31:0] z_zw;
        logic        ovf_zw;
        logic [31:0] z_mod;
        logic        ovf_mod;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: a 64-bit widening shift exposes the spilled bits directly.
    function automatic void model(input logic [31:0] op, input logic [31:0] amt,
                                  input bit zw, output logic [31:0] z, output logic o);
        logic [63:0] w;
        int n;
        if (zw && amt >= 32) begin
            z = 32'd0;
            o = (op != 32'd0);
        end else begin
            n = int'(amt % 32);
            w = {32'd0, op} << n;
            z = w[31:0];
            o = (w[63:32] != 32'd0);
        end
    endfunction

    // One complete operation, all checks timed from the negative edge.
    task automatic run_op(input logic [31:0] op, input logic [31:0] amt,
                          input logic [31:0] ez_zw, input logic eo_zw,
                          input logic [31:0] ez_mod, input logic eo_mod);
        @(negedge clk);
        bus_in = op;
        start  = 1'b1;
        @(negedge clk);                               // WAIT_AMT
        start = 1'b0;
        chk("busy_wait", busy_zw, 1'b1);
        chk("operand", shf_operand_zw, op);
        chk("z_hold_zw", z_out_zw, prev_z_zw);
        chk("z_hold_mod", z_out_mod, prev_z_mod);
        bus_in    = amt;
        amt_valid = 1'b1;
        @(negedge clk);                               // EXEC
        amt_valid = 1'b0;
        bus_in    = $urandom;
        chk("busy_exec", busy_mod, 1'b1);
        chk("done_early", done_zw, 1'b0);
        chk("amount", shf_amount_mod, amt[4:0]);
        @(negedge clk);                               // DONE
        chk("done_zw", done_zw, 1'b1);
        chk("done_mod", done_mod, 1'b1);
        chk("z_zw", z_out_zw, ez_zw);
        chk("ovf_zw", ovf_zw, eo_zw);
        chk("z_mod", z_out_mod, ez_mod);
        chk("ovf_mod", ovf_mod, eo_mod);
        @(negedge clk);                               // IDLE
        chk("done_pulse", done_zw, 1'b0);
        chk("busy_idle", busy_zw, 1'b0);
        $display("op=%h amt=%h -> zw z=%h ovf=%b | mod z=%h ovf=%b",
                 op, amt, z_out_zw, ovf_zw, z_out_mod, ovf_mod);
        prev_z_zw  = ez_zw;
        prev_z_mod = ez_mod;
        prev_amt   = amt[4:0];
    endtask

    vec_t vecs[8];

    initial begin
        logic [31:0] rop, ramt, mz0, mz1;
        logic        mo0, mo1;

        vecs[0] = '{32'h0000_0001, 32'd4,  32'h0000_0010, 1'b0, 32'h0000_0010, 1'b0};
        vecs[1] = '{32'h8000_0001, 32'd1,  32'h0000_0002, 1'b1, 32'h0000_0002, 1'b1};
        vecs[2] = '{32'h0000_00FF, 32'h20, 32'h0000_0000, 1'b1, 32'h0000_00FF, 1'b0};
        vecs[3] = '{32'hDEAD_BEEF, 32'd0,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 32'd31, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1};
        vecs[5] = '{32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0};
        vecs[6] = '{32'h0000_0000, 32'h40, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[7] = '{32'hF000_0000, 32'd36, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};

        clear     = 1'b1;
        bus_in    = 32'd0;
        start     = 1'b0;
        amt_valid = 1'b0;
        prev_z_zw  = 32'd0;
        prev_z_mod = 32'd0;
        prev_amt   = 5'd0;

        // Reset state, before any clock edge
        #3;
        chk("rst_busy", busy_zw, 1'b0);
        chk("rst_done", done_zw, 1'b0);
        chk("rst_z", z_out_zw, 32'd0);
        chk("rst_ovf", ovf_zw, 1'b0);
        chk("rst_operand", shf_operand_mod, 32'd0);
        chk("rst_amount", shf_amount_mod, 5'd0);
        @(negedge clk);
        @(negedge clk);
        clear = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].amt, vecs[i].z_zw, vecs[i].ovf_zw,
                   vecs[i].z_mod, vecs[i].ovf_mod);
        end

        // amt_valid alone in IDLE does nothing
        @(negedge clk);
        bus_in    = 32'd7;
        amt_valid = 1'b1;
        @(negedge clk);
        amt_valid = 1'b0;
        chk("ign_amt_busy", busy_zw, 1'b0);
        chk("ign_amt_amount", shf_amount_zw, prev_amt);

        // start with amt_valid in IDLE: only start acts
        bus_in    = 32'd5;
        start     = 1'b1;
        amt_valid = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        amt_valid = 1'b0;
        chk("both_operand", shf_operand_zw, 32'd5);
        chk("both_amount", shf_amount_zw, prev_amt);
        for (int i = 0; i < 3; i++) begin
            chk("wait_busy", busy_zw, 1'b1);
            chk("wait_done", done_zw, 1'b0);
            if (i == 0) begin
                bus_in = 32'h1234;
                start  = 1'b1;
            end else begin
                start = 1'b0;
                chk("second_start_ignored", shf_operand_zw, 32'd5);
            end
            @(negedge clk);
        end
        start     = 1'b0;
        bus_in    = 32'd3;
        amt_valid = 1'b1;
        @(negedge clk);
        amt_valid = 1'b0;
        chk("ign_exec_done", done_zw, 1'b0);
        @(negedge clk);
        chk("ign_done", done_zw, 1'b1);
        chk("ign_z_zw", z_out_zw, 32'h28);
        chk("ign_z_mod", z_out_mod, 32'h28);
        chk("ign_ovf", ovf_zw, 1'b0);
        $display("op=%h amt=%h -> zw z=%h ovf=%b | mod z=%h ovf=%b (ignored strobes)",
                 32'd5, 32'd3, z_out_zw, ovf_zw, z_out_mod, ovf_mod);
        @(negedge clk);
        prev_z_zw  = 32'h28;
        prev_z_mod = 32'h28;
        prev_amt   = 5'd3;

        // Clear during EXEC aborts the operation
        @(negedge clk);
        bus_in = 32'h0000_AAAA;
        start  = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        bus_in    = 32'd2;
        amt_valid = 1'b1;
        @(negedge clk);
        amt_valid = 1'b0;
        chk("abort_in_exec", busy_zw, 1'b1);
        #2 clear = 1'b1;
        #1;
        chk("abort_busy", busy_zw, 1'b0);
        chk("abort_z", z_out_zw, 32'd0);
        chk("abort_z_mod", z_out_mod, 32'd0);
        chk("abort_ovf", ovf_zw, 1'b0);
        chk("abort_done", done_zw, 1'b0);
        @(negedge clk);
        clear = 1'b0;
        chk("abort_no_done", done_zw, 1'b0);
        @(negedge clk);
        chk("abort_no_done2", done_mod, 1'b0);
        chk("abort_idle", busy_mod, 1'b0);
        $display("clear during EXEC -> busy=%b z=%h done=%b", busy_zw, z_out_zw, done_zw);
        prev_z_zw  = 32'd0;
        prev_z_mod = 32'd0;
        prev_amt   = 5'd0;
        run_op(32'd3, 32'd2, 32'h0000_000C, 1'b0, 32'h0000_000C, 1'b0);

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = $urandom;
            if (i % 4 == 0) rop = rop >> $urandom_range(0, 31);
            case ($urandom_range(0, 3))
                0:       ramt = 32'($urandom_range(0, 31));
                1:       ramt = 32'($urandom_range(32, 70));
                2:       ramt = $urandom;
                default: ramt = 32'($urandom_range(0, 3));
            endcase
            model(rop, ramt, 1'b1, mz0, mo0);
            model(rop, ramt, 1'b0, mz1, mo1);
            run_op(rop, ramt, mz0, mo0, mz1, mo1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
